// File: rtl/partial_pkg.sv
// -----------------------------------------------------------------------------
// partial_pkg
// Shared widths, the serializer state type and a byte-select helper for the
// partial test system transmit path.
// -----------------------------------------------------------------------------
package partial_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int STAT_W = 4;
  // One FIFO entry / hold register: {status, data}
  localparam int HOLD_W = WORD_W + STAT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10
  } ser_state_e;

  // Returns the upper byte of a word when upper is set, the lower byte otherwise.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                   input logic              upper);
    if (upper) begin
      pick_byte = word[WORD_W-1 -: BYTE_W];
    end else begin
      pick_byte = word[BYTE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/partial_word_fifo.sv
// -----------------------------------------------------------------------------
// partial_word_fifo
// Small synchronous FIFO with combinational read data (head entry always
// visible on rdata_o).
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset (pointers only)
//   push_i   write wdata_i when not full
//   wdata_i  entry to store
//   pop_i    discard the head entry when not empty
//   rdata_o  head entry
//   full_o   DEPTH entries stored
//   empty_o  no entries stored
// -----------------------------------------------------------------------------
module partial_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/partial_word_serializer.sv
// -----------------------------------------------------------------------------
// partial_word_serializer
// Buffers 16-bit words (+4-bit status) in a FIFO and emits each one as two
// byte beats, each beat carrying its half of the status.
// Ports:
//   sys_clk, sys_reset   clock / async active-low reset
//   enable               permits loading the next word from the FIFO
//   word_valid/ready     word handshake (ready = FIFO not full)
//   word_data/status     word payload / status
//   byte_valid/ready     beat handshake
//   byte_data/status     beat payload / status half ([3:2] first, [1:0] second)
//   byte_last            high on the second beat
//   busy                 beat in flight or FIFO non-empty
//   word_count           completed words, wraps at 256
// -----------------------------------------------------------------------------
module partial_word_serializer
  import partial_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              enable,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  input  logic [STAT_W-1:0] word_status,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic [1:0]        byte_status,
  output logic              byte_last,
  output logic              busy,
  output logic [7:0]        word_count
);

  ser_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        count_q, count_d;
  logic              load;
  logic              fifo_full;
  logic              fifo_empty;
  logic [HOLD_W-1:0] fifo_rdata;

  partial_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (HOLD_W)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_reset),
    .push_i  (word_valid),
    .wdata_i ({word_status, word_data}),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_ready = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign word_count = count_q;

  // Next-state, FIFO pop and word counter logic.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && enable) begin
          state_d = FIRST;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FIRST: begin
        if (byte_ready) begin
          state_d = SECOND;
        end else begin
          state_d = FIRST;
        end
      end
      SECOND: begin
        if (byte_ready) begin
          count_d = count_q + 8'd1;
          // Reload straight from SECOND so back-to-back words have no bubble.
          if (!fifo_empty && enable) begin
            state_d = FIRST;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SECOND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      hold_d = fifo_rdata;
    end else begin
      hold_d = hold_q;
    end
  end

  // State, hold register and word counter.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  // Beat outputs decoded from state and hold register only, so they stay
  // stable under backpressure. Idle drives zeros.
  always_comb begin
    byte_valid  = 1'b0;
    byte_last   = 1'b0;
    byte_data   = '0;
    byte_status = 2'b00;
    case (state_q)
      IDLE: begin
        byte_valid  = 1'b0;
      end
      FIRST: begin
        byte_valid  = 1'b1;
        byte_data   = pick_byte(hold_q[WORD_W-1:0], MSB_FIRST);
        byte_status = hold_q[HOLD_W-1 -: 2];
      end
      SECOND: begin
        byte_valid  = 1'b1;
        byte_last   = 1'b1;
        byte_data   = pick_byte(hold_q[WORD_W-1:0], !MSB_FIRST);
        byte_status = hold_q[WORD_W +: 2];
      end
      default: begin
        byte_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_partial_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_partial_word_serializer
// Two instances (MSB-first and LSB-first) share all inputs. Directed table and
// corner sequences, then random traffic against a queue-based reference.
// -----------------------------------------------------------------------------
module tb_partial_word_serializer;

  localparam int DEPTH = 2;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b0;
  logic        enable = 1'b0;
  logic        word_valid = 1'b0;
  logic        byte_ready = 1'b0;
  logic [15:0] word_data = 16'h0000;
  logic [3:0]  word_status = 4'h0;

  logic        word_ready, byte_valid, byte_last, busy;
  logic [7:0]  byte_data, word_count;
  logic [1:0]  byte_status;
  logic        l_word_ready, l_byte_valid, l_byte_last, l_busy;
  logic [7:0]  l_byte_data, l_word_count;
  logic [1:0]  l_byte_status;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_wc;

  always #5 sys_clk = ~sys_clk;

  partial_word_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .enable(enable),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_status(word_status), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .byte_status(byte_status), .byte_last(byte_last),
    .busy(busy), .word_count(word_count)
  );

  partial_word_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .enable(enable),
    .word_valid(word_valid), .word_ready(l_word_ready), .word_data(word_data),
    .word_status(word_status), .byte_valid(l_byte_valid), .byte_ready(byte_ready),
    .byte_data(l_byte_data), .byte_status(l_byte_status), .byte_last(l_byte_last),
    .busy(l_busy), .word_count(l_word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  // Checks one beat on both instances; m/l are the MSB-first / LSB-first bytes.
  task automatic chk_beat(input string name, input logic [7:0] m, input logic [7:0] l,
                          input logic [1:0] s, input logic last);
    chk({name, "_valid"}, 32'(byte_valid), 32'd1);
    chk({name, "_data"}, 32'(byte_data), 32'(m));
    chk({name, "_ldata"}, 32'(l_byte_data), 32'(l));
    chk({name, "_status"}, 32'(byte_status), 32'(s));
    chk({name, "_lstatus"}, 32'(l_byte_status), 32'(s));
    chk({name, "_last"}, 32'(byte_last), 32'(last));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic send_words(input int n);
    int acc = 0;
    int guard = 0;
    word_valid = 1'b1;
    byte_ready = 1'b1;
    enable = 1'b1;
    while (acc < n && guard < 4 * n + 20) begin
      word_data = 16'($urandom);
      word_status = 4'($urandom);
      if (word_ready) acc++;
      step();
      guard++;
    end
    word_valid = 1'b0;
    chk("wrap_accepted", 32'(acc), 32'(n));
    wait_idle("wrap");
  endtask

  typedef struct {
    logic [15:0] w;
    logic [3:0]  st;
    logic [7:0]  b0, b1;
    logic [1:0]  s0, s1;
  } vec_t;

  typedef struct {
    logic [7:0] m, l;
    logic [1:0] s;
    logic       last;
  } beat_t;

  // Random-phase reference: words waiting in the FIFO, beats of the word in flight.
  logic [19:0] mq[$];
  beat_t       bq[$];
  logic [7:0]  m_wc;

  initial begin
    vec_t        vecs[5];
    logic [15:0] bb_w[3];
    logic [7:0]  bb_m[6];
    logic [7:0]  bb_l[6];
    logic [15:0] bp_w[4];
    logic [3:0]  bp_s[4];
    logic        w4_seen;

    vecs[0] = '{16'hA55A, 4'hD, 8'hA5, 8'h5A, 2'b11, 2'b01};
    vecs[1] = '{16'h0000, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00};
    vecs[2] = '{16'hFFFF, 4'hF, 8'hFF, 8'hFF, 2'b11, 2'b11};
    vecs[3] = '{16'h1234, 4'h6, 8'h12, 8'h34, 2'b01, 2'b10};
    vecs[4] = '{16'h8001, 4'h9, 8'h80, 8'h01, 2'b10, 2'b01};
    bb_w = '{16'h1122, 16'h3344, 16'h5566};
    bb_m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bb_l = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55};
    bp_w = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789};
    bp_s = '{4'hC, 4'h3, 4'h9, 4'h6};

    // ---------------- reset values
    step();
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_data", 32'(byte_data), 32'd0);
    chk("rst_status", 32'(byte_status), 32'd0);
    chk("rst_last", 32'(byte_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_ready", 32'(word_ready), 32'd1);
    chk("rst_lvalid", 32'(l_byte_valid), 32'd0);
    sys_reset = 1'b1;
    step();
    exp_wc = 8'd0;

    // ---------------- single words from the table
    for (int i = 0; i < 5; i++) begin
      enable = 1'b1;
      byte_ready = 1'b1;
      word_valid = 1'b1;
      word_data = vecs[i].w;
      word_status = vecs[i].st;
      step();
      word_valid = 1'b0;
      chk("tbl_lat_valid", 32'(byte_valid), 32'd0);
      chk("tbl_lat_busy", 32'(busy), 32'd1);
      step();
      chk_beat("tbl_b0", vecs[i].b0, vecs[i].b1, vecs[i].s0, 1'b0);
      step();
      chk_beat("tbl_b1", vecs[i].b1, vecs[i].b0, vecs[i].s1, 1'b1);
      step();
      exp_wc = exp_wc + 8'd1;
      chk("tbl_done_valid", 32'(byte_valid), 32'd0);
      chk("tbl_count", 32'(word_count), 32'(exp_wc));
    end

    // ---------------- back-to-back words, no gaps
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        word_valid = 1'b1;
        word_data = bb_w[i];
        word_status = 4'h0;
        chk("bb_ready", 32'(word_ready), 32'd1);
      end else begin
        word_valid = 1'b0;
      end
      if (i >= 2) chk_beat("bb_beat", bb_m[i-2], bb_l[i-2], 2'b00, 1'((i - 2) % 2));
      step();
    end
    exp_wc = exp_wc + 8'd3;
    chk("bb_end_valid", 32'(byte_valid), 32'd0);
    chk("bb_count", 32'(word_count), 32'(exp_wc));

    // ---------------- backpressure and full
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_data = bp_w[i];
      word_status = bp_s[i];
      chk("bp_accept", 32'(word_ready), 32'd1);
      step();
    end
    word_data = bp_w[3];
    word_status = bp_s[3];
    for (int k = 0; k < 10; k++) begin
      chk("bp_full", 32'(word_ready), 32'd0);
      chk_beat("bp_hold", 8'hA1, 8'hB2, 2'b11, 1'b0);
      step();
    end
    byte_ready = 1'b1;
    w4_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (word_valid && word_ready) w4_seen = 1'b1;
      if (k % 2 == 0) begin
        chk_beat("bp_beat", bp_w[k/2][15:8], bp_w[k/2][7:0], bp_s[k/2][3:2], 1'b0);
      end else begin
        chk_beat("bp_beat", bp_w[k/2][7:0], bp_w[k/2][15:8], bp_s[k/2][1:0], 1'b1);
      end
      step();
      if (w4_seen) word_valid = 1'b0;
    end
    chk("bp_w4_accepted", 32'(w4_seen), 32'd1);
    chk("bp_end_valid", 32'(byte_valid), 32'd0);
    exp_wc = exp_wc + 8'd4;
    chk("bp_count", 32'(word_count), 32'(exp_wc));

    // ---------------- enable dropped during FIRST
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_data = {8'(2 * i + 1), 8'(2 * i + 2)};
      word_status = 4'h5;
      step();
    end
    word_valid = 1'b0;
    enable = 1'b0;
    byte_ready = 1'b1;
    chk_beat("en_b0", 8'h01, 8'h02, 2'b01, 1'b0);
    step();
    chk_beat("en_b1", 8'h02, 8'h01, 2'b01, 1'b1);
    step();
    exp_wc = exp_wc + 8'd1;
    for (int k = 0; k < 3; k++) begin
      chk("en_stall_valid", 32'(byte_valid), 32'd0);
      chk("en_stall_busy", 32'(busy), 32'd1);
      step();
    end
    chk("en_stall_count", 32'(word_count), 32'(exp_wc));
    enable = 1'b1;
    step();
    chk_beat("en_resume", 8'h03, 8'h04, 2'b01, 1'b0);
    step();
    chk_beat("en_resume", 8'h04, 8'h03, 2'b01, 1'b1);
    step();
    chk_beat("en_resume", 8'h05, 8'h06, 2'b01, 1'b0);
    step();
    chk_beat("en_resume", 8'h06, 8'h05, 2'b01, 1'b1);
    step();
    exp_wc = exp_wc + 8'd2;
    chk("en_end_busy", 32'(busy), 32'd0);
    chk("en_count", 32'(word_count), 32'(exp_wc));

    // ---------------- reset during SECOND with words queued
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_data = 16'hBEEF;
      word_status = 4'hE;
      step();
    end
    word_valid = 1'b0;
    byte_ready = 1'b1;
    step();
    byte_ready = 1'b0;
    chk("rs_in_second", 32'(byte_last), 32'd1);
    #2;
    sys_reset = 1'b0;
    #1;
    chk("rs_valid", 32'(byte_valid), 32'd0);
    chk("rs_last", 32'(byte_last), 32'd0);
    chk("rs_data", 32'(byte_data), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_ready", 32'(word_ready), 32'd1);
    chk("rs_count", 32'(word_count), 32'd0);
    step();
    sys_reset = 1'b1;
    byte_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rs_after_valid", 32'(byte_valid), 32'd0);
      chk("rs_after_busy", 32'(busy), 32'd0);
    end

    // ---------------- word_count wrap
    send_words(255);
    chk("wrap_255", 32'(word_count), 32'd255);
    send_words(1);
    chk("wrap_0", 32'(word_count), 32'd0);

    // ---------------- random traffic against the queue reference
    sys_reset = 1'b0;
    word_valid = 1'b0;
    step();
    sys_reset = 1'b1;
    step();
    mq.delete();
    bq.delete();
    m_wc = 8'd0;
    for (int c = 0; c < 2000; c++) begin
      logic pop, push, load;
      logic [19:0] w;
      word_valid = ($urandom_range(0, 9) < 7);
      byte_ready = ($urandom_range(0, 9) < 7);
      enable = ($urandom_range(0, 9) < 9);
      word_data = 16'($urandom);
      word_status = 4'($urandom);

      chk("rnd_valid", 32'(byte_valid), 32'(bq.size() != 0));
      chk("rnd_lvalid", 32'(l_byte_valid), 32'(bq.size() != 0));
      chk("rnd_ready", 32'(word_ready), 32'(mq.size() < DEPTH));
      chk("rnd_lready", 32'(l_word_ready), 32'(mq.size() < DEPTH));
      chk("rnd_busy", 32'(busy), 32'(bq.size() != 0 || mq.size() != 0));
      chk("rnd_lbusy", 32'(l_busy), 32'(bq.size() != 0 || mq.size() != 0));
      chk("rnd_count", 32'(word_count), 32'(m_wc));
      chk("rnd_lcount", 32'(l_word_count), 32'(m_wc));
      if (bq.size() != 0) begin
        chk_beat("rnd_beat", bq[0].m, bq[0].l, bq[0].s, bq[0].last);
        chk("rnd_llast", 32'(l_byte_last), 32'(bq[0].last));
      end

      pop = (bq.size() != 0) && byte_ready;
      push = word_valid && (mq.size() < DEPTH);
      load = (mq.size() != 0) && enable && (bq.size() == 0 || (bq.size() == 1 && pop));
      if (pop) begin
        if (bq[0].last) m_wc = m_wc + 8'd1;
        void'(bq.pop_front());
      end
      if (load) begin
        w = mq.pop_front();
        bq.push_back('{w[15:8], w[7:0], w[19:18], 1'b0});
        bq.push_back('{w[7:0], w[15:8], w[17:16], 1'b1});
      end
      if (push) mq.push_back({word_status, word_data});
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
